// File: rtl/alu_rs_scheduler_if.sv
// Dispatch / CDB / ALU / result bundle between the ALU reservation station and its neighbours.
// slave is the reservation station side, master is the surrounding core (dispatcher, CDB, ALU).
interface alu_rs_scheduler_if #(
   parameter int ROB_WIDTH = 4
);
   logic                 disp_valid;
   logic [5:0]           disp_op;
   logic [31:0]          disp_imm;
   logic                 disp_qj_busy;
   logic [ROB_WIDTH-1:0] disp_qj;
   logic [31:0]          disp_vj;
   logic                 disp_qk_busy;
   logic [ROB_WIDTH-1:0] disp_qk;
   logic [31:0]          disp_vk;
   logic [ROB_WIDTH-1:0] disp_tag;
   logic                 rs_full;
   logic                 cdb_valid;
   logic [ROB_WIDTH-1:0] cdb_tag;
   logic [31:0]          cdb_value;
   logic [31:0]          alu_vj;
   logic [31:0]          alu_vk;
   logic [31:0]          alu_imm;
   logic [5:0]           alu_op;
   logic                 alu_waiting;
   logic                 alu_finish;
   logic [31:0]          alu_value;
   logic                 res_valid;
   logic [ROB_WIDTH-1:0] res_tag;
   logic [31:0]          res_value;

   modport slave (
      input  disp_valid, disp_op, disp_imm, disp_qj_busy, disp_qj, disp_vj,
             disp_qk_busy, disp_qk, disp_vk, disp_tag,
             cdb_valid, cdb_tag, cdb_value, alu_finish, alu_value,
      output rs_full, alu_vj, alu_vk, alu_imm, alu_op, alu_waiting,
             res_valid, res_tag, res_value
   );

   modport master (
      output disp_valid, disp_op, disp_imm, disp_qj_busy, disp_qj, disp_vj,
             disp_qk_busy, disp_qk, disp_vk, disp_tag,
             cdb_valid, cdb_tag, cdb_value, alu_finish, alu_value,
      input  rs_full, alu_vj, alu_vk, alu_imm, alu_op, alu_waiting,
             res_valid, res_tag, res_value
   );
endinterface

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: tag-based operand wakeup, lowest-index select, one issue per cycle.
// Optional macro ALU_RS_SELF_BYPASS_EN adds the tagged ALU result as a second wakeup source.
module alu_rs_entry #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 flush,
   input  logic                 en,
   input  logic                 wr,
   input  logic                 issue,
   input  logic [5:0]           d_op,
   input  logic [31:0]          d_imm,
   input  logic                 d_qj_busy,
   input  logic [ROB_WIDTH-1:0] d_qj,
   input  logic [31:0]          d_vj,
   input  logic                 d_qk_busy,
   input  logic [ROB_WIDTH-1:0] d_qk,
   input  logic [31:0]          d_vk,
   input  logic [ROB_WIDTH-1:0] d_tag,
   input  logic                 wa_valid,
   input  logic [ROB_WIDTH-1:0] wa_tag,
   input  logic [31:0]          wa_value,
   input  logic                 wb_valid,
   input  logic [ROB_WIDTH-1:0] wb_tag,
   input  logic [31:0]          wb_value,
   output logic                 busy,
   output logic                 ready,
   output logic [5:0]           op,
   output logic [31:0]          imm,
   output logic [31:0]          vj,
   output logic [31:0]          vk,
   output logic [ROB_WIDTH-1:0] tag
);
   logic                 qj_busy, qk_busy, jb_s, kb_s, jb_n, kb_n;
   logic [ROB_WIDTH-1:0] qj, qk, qj_s, qk_s;
   logic [31:0]          vj_s, vk_s, vj_n, vk_n;

   // Operand source is the incoming dispatch on a write, so a same-cycle broadcast is caught.
   always_comb begin
      jb_s = wr ? d_qj_busy : qj_busy;
      qj_s = wr ? d_qj      : qj;
      vj_s = wr ? d_vj      : vj;
      kb_s = wr ? d_qk_busy : qk_busy;
      qk_s = wr ? d_qk      : qk;
      vk_s = wr ? d_vk      : vk;
      jb_n = jb_s;
      vj_n = vj_s;
      kb_n = kb_s;
      vk_n = vk_s;
      if (jb_s && wa_valid && wa_tag == qj_s) begin
         jb_n = 1'b0;
         vj_n = wa_value;
      end else if (jb_s && wb_valid && wb_tag == qj_s) begin
         jb_n = 1'b0;
         vj_n = wb_value;
      end
      if (kb_s && wa_valid && wa_tag == qk_s) begin
         kb_n = 1'b0;
         vk_n = wa_value;
      end else if (kb_s && wb_valid && wb_tag == qk_s) begin
         kb_n = 1'b0;
         vk_n = wb_value;
      end
   end

   always_ff @(posedge clk_in) begin
      if (flush) begin
         busy <= 1'b0;
      end else if (en) begin
         if (wr) begin
            busy <= 1'b1;
            op   <= d_op;
            imm  <= d_imm;
            tag  <= d_tag;
            qj   <= d_qj;
            qk   <= d_qk;
         end else if (issue) begin
            busy <= 1'b0;
         end
         qj_busy <= jb_n;
         vj      <= vj_n;
         qk_busy <= kb_n;
         vk      <= vk_n;
      end
   end

   assign ready = busy && !qj_busy && !qk_busy;
endmodule

module alu_rs_scheduler #(
   parameter int RS_SIZE   = 8,
   parameter int ROB_WIDTH = 4
) (
   input logic          clk_in,
   input logic          rst_in,
   input logic          rdy_in,
   input logic          RoB_clear,
   alu_rs_scheduler_if.slave bus
);
   localparam int IW = $clog2(RS_SIZE);

   logic                                flush, disp_go, any_rdy;
   logic [IW-1:0]                       sel, free_idx;
   logic [RS_SIZE-1:0]                  e_busy, e_ready, wr_vec, iss_vec;
   logic [RS_SIZE-1:0][5:0]             e_op;
   logic [RS_SIZE-1:0][31:0]            e_imm, e_vj, e_vk;
   logic [RS_SIZE-1:0][ROB_WIDTH-1:0]   e_tag;
   logic                                wb_valid;
   logic [ROB_WIDTH-1:0]                wb_tag;
   logic [31:0]                         wb_value;
   logic                                rs_full_q, alu_waiting_q;
   logic [5:0]                          alu_op_q;
   logic [31:0]                         alu_vj_q, alu_vk_q, alu_imm_q;
   logic [ROB_WIDTH-1:0]                issue_tag, res_tag_q;

   assign flush = rst_in || RoB_clear;

`ifdef ALU_RS_SELF_BYPASS_EN
   assign wb_valid = bus.alu_finish;
   assign wb_tag   = res_tag_q;
   assign wb_value = bus.alu_value;
`else
   assign wb_valid = 1'b0;
   assign wb_tag   = '0;
   assign wb_value = '0;
`endif

   // Downward scan leaves the lowest index in sel / free_idx.
   always_comb begin
      any_rdy  = 1'b0;
      sel      = '0;
      free_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (e_ready[i]) begin
            any_rdy = 1'b1;
            sel     = IW'(i);
         end
         if (!e_busy[i]) free_idx = IW'(i);
      end
   end

   assign disp_go = bus.disp_valid && !rs_full_q;

   for (genvar i = 0; i < RS_SIZE; i++) begin : g_ent
      assign wr_vec[i]  = disp_go && (free_idx == IW'(i));
      assign iss_vec[i] = any_rdy && (sel == IW'(i));
      alu_rs_entry #(.ROB_WIDTH(ROB_WIDTH)) u_ent (
         .clk_in    (clk_in),
         .flush     (flush),
         .en        (rdy_in),
         .wr        (wr_vec[i]),
         .issue     (iss_vec[i]),
         .d_op      (bus.disp_op),
         .d_imm     (bus.disp_imm),
         .d_qj_busy (bus.disp_qj_busy),
         .d_qj      (bus.disp_qj),
         .d_vj      (bus.disp_vj),
         .d_qk_busy (bus.disp_qk_busy),
         .d_qk      (bus.disp_qk),
         .d_vk      (bus.disp_vk),
         .d_tag     (bus.disp_tag),
         .wa_valid  (bus.cdb_valid),
         .wa_tag    (bus.cdb_tag),
         .wa_value  (bus.cdb_value),
         .wb_valid  (wb_valid),
         .wb_tag    (wb_tag),
         .wb_value  (wb_value),
         .busy      (e_busy[i]),
         .ready     (e_ready[i]),
         .op        (e_op[i]),
         .imm       (e_imm[i]),
         .vj        (e_vj[i]),
         .vk        (e_vk[i]),
         .tag       (e_tag[i])
      );
   end

   // Occupancy ignores this cycle's issue, so a freed slot shows up one cycle later.
   always_ff @(posedge clk_in) begin
      if (flush) begin
         rs_full_q     <= 1'b0;
         alu_waiting_q <= 1'b0;
         alu_op_q      <= '0;
         alu_vj_q      <= '0;
         alu_vk_q      <= '0;
         alu_imm_q     <= '0;
         issue_tag     <= '0;
         res_tag_q     <= '0;
      end else if (rdy_in) begin
         rs_full_q     <= &(e_busy | wr_vec);
         alu_waiting_q <= any_rdy;
         if (any_rdy) begin
            alu_op_q  <= e_op[sel];
            alu_vj_q  <= e_vj[sel];
            alu_vk_q  <= e_vk[sel];
            alu_imm_q <= e_imm[sel];
            issue_tag <= e_tag[sel];
         end
         if (alu_waiting_q) res_tag_q <= issue_tag;
      end
   end

   assign bus.rs_full     = rs_full_q;
   assign bus.alu_waiting = alu_waiting_q;
   assign bus.alu_op      = alu_op_q;
   assign bus.alu_vj      = alu_vj_q;
   assign bus.alu_vk      = alu_vk_q;
   assign bus.alu_imm     = alu_imm_q;
   assign bus.res_valid   = bus.alu_finish;
   assign bus.res_tag     = res_tag_q;
   assign bus.res_value   = bus.alu_value;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed scenarios plus random traffic against a pending-op model.
module tb_alu_rs_scheduler;
   localparam int RS = 8;
   localparam int RW = 4;

   logic clk_in = 1'b0;
   logic rst_in, rdy_in, RoB_clear;
   int   n_chk = 0, n_pass = 0;
   bit   chk_on = 1'b0;

   alu_rs_scheduler_if #(.ROB_WIDTH(RW)) bus ();

   alu_rs_scheduler #(.RS_SIZE(RS), .ROB_WIDTH(RW)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .RoB_clear (RoB_clear),
      .bus       (bus)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] imm);
      case (op)
         6'd0:    return a + b;
         6'd1:    return a + imm;
         6'd2:    return a - b;
         6'd3:    return a ^ b;
         6'd63:   return 32'd0;
         default: return a | b;
      endcase
   endfunction

   // ALU stand-in: samples on the edge that sees alu_waiting, answers one cycle later.
   always @(posedge clk_in) begin
      if (rst_in || RoB_clear) begin
         bus.alu_finish <= 1'b0;
         bus.alu_value  <= 32'd0;
      end else if (rdy_in) begin
         bus.alu_finish <= bus.alu_waiting;
         bus.alu_value  <= alu_f(bus.alu_op, bus.alu_vj, bus.alu_vk, bus.alu_imm);
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model: slots of pending ops ----------------
   typedef struct {
      logic          busy;
      logic [5:0]    op;
      logic [31:0]   imm, vj, vk;
      logic          jp, kp;
      logic [RW-1:0] qj, qk, tag;
   } ent_t;

   ent_t          m_e[RS];
   logic          m_full, m_wait, m_fin;
   logic [5:0]    m_op;
   logic [31:0]   m_vj, m_vk, m_imm, m_rval;
   logic [RW-1:0] m_itag, m_rtag;

   function automatic ent_t wake(input ent_t e, input logic ov, input logic [RW-1:0] ot,
                                 input logic [31:0] oval);
      if (e.jp && bus.cdb_valid && bus.cdb_tag == e.qj) begin e.vj = bus.cdb_value; e.jp = 1'b0; end
      else if (e.jp && ov && ot == e.qj) begin e.vj = oval; e.jp = 1'b0; end
      if (e.kp && bus.cdb_valid && bus.cdb_tag == e.qk) begin e.vk = bus.cdb_value; e.kp = 1'b0; end
      else if (e.kp && ov && ot == e.qk) begin e.vk = oval; e.kp = 1'b0; end
      return e;
   endfunction

   always @(posedge clk_in) begin : mdl
      int            s, f, cnt;
      logic          dgo, ofin, nfin;
      logic [RW-1:0] ortag;
      logic [31:0]   orval, nrval;
      ent_t          ne;
      if (rst_in || RoB_clear) begin
         for (int i = 0; i < RS; i++) m_e[i].busy = 1'b0;
         m_full = 0; m_wait = 0; m_fin = 0; m_op = 0; m_vj = 0; m_vk = 0; m_imm = 0;
         m_rval = 0; m_itag = 0; m_rtag = 0;
      end else if (rdy_in) begin
         s = -1; f = -1; cnt = 0;
         for (int i = 0; i < RS; i++) begin
            if (s < 0 && m_e[i].busy && !m_e[i].jp && !m_e[i].kp) s = i;
            if (f < 0 && !m_e[i].busy) f = i;
            if (m_e[i].busy) cnt++;
         end
         dgo = bus.disp_valid && !m_full && f >= 0;
`ifdef ALU_RS_SELF_BYPASS_EN
         ofin = m_fin;
`else
         ofin = 1'b0;
`endif
         ortag = m_rtag; orval = m_rval;
         nfin  = m_wait;
         nrval = alu_f(m_op, m_vj, m_vk, m_imm);
         if (m_wait) m_rtag = m_itag;
         for (int i = 0; i < RS; i++) if (m_e[i].busy) m_e[i] = wake(m_e[i], ofin, ortag, orval);
         if (s >= 0) begin
            m_op = m_e[s].op; m_vj = m_e[s].vj; m_vk = m_e[s].vk; m_imm = m_e[s].imm;
            m_itag = m_e[s].tag; m_e[s].busy = 1'b0; m_wait = 1'b1;
         end else m_wait = 1'b0;
         m_full = (cnt + (dgo ? 1 : 0)) == RS;
         if (dgo) begin
            ne.busy = 1'b1; ne.op = bus.disp_op; ne.imm = bus.disp_imm; ne.tag = bus.disp_tag;
            ne.jp = bus.disp_qj_busy; ne.qj = bus.disp_qj; ne.vj = bus.disp_vj;
            ne.kp = bus.disp_qk_busy; ne.qk = bus.disp_qk; ne.vk = bus.disp_vk;
            m_e[f] = wake(ne, ofin, ortag, orval);
         end
         m_fin = nfin; m_rval = nrval;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk_in) begin
      if (chk_on) begin
         check("rs_full", 32'(bus.rs_full), 32'(m_full));
         check("alu_waiting", 32'(bus.alu_waiting), 32'(m_wait));
         if (m_wait) begin
            check("alu_op", 32'(bus.alu_op), 32'(m_op));
            check("alu_vj", bus.alu_vj, m_vj);
            check("alu_vk", bus.alu_vk, m_vk);
            check("alu_imm", bus.alu_imm, m_imm);
         end
         check("res_valid", 32'(bus.res_valid), 32'(m_fin));
         if (m_fin) begin
            check("res_tag", 32'(bus.res_tag), 32'(m_rtag));
            check("res_value", bus.res_value, m_rval);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk_in);
   endtask

   task automatic disp(input logic [5:0] op, input logic [31:0] imm,
                       input logic jb, input logic [RW-1:0] qj, input logic [31:0] vj,
                       input logic kb, input logic [RW-1:0] qk, input logic [31:0] vk,
                       input logic [RW-1:0] tag);
      bus.disp_valid = 1'b1; bus.disp_op = op; bus.disp_imm = imm;
      bus.disp_qj_busy = jb; bus.disp_qj = qj; bus.disp_vj = vj;
      bus.disp_qk_busy = kb; bus.disp_qk = qk; bus.disp_vk = vk; bus.disp_tag = tag;
   endtask

   task automatic cdb(input logic v, input logic [RW-1:0] t, input logic [31:0] val);
      bus.cdb_valid = v; bus.cdb_tag = t; bus.cdb_value = val;
   endtask

   task automatic wait_res(input logic [RW-1:0] tag, input int lim, output logic seen,
                           output logic [31:0] val);
      seen = 1'b0; val = 32'd0;
      for (int c = 0; c < lim && !seen; c++) begin
         step();
         if (bus.res_valid && bus.res_tag == tag) begin seen = 1'b1; val = bus.res_value; end
      end
   endtask

   logic          seen;
   logic [31:0]   val;
   logic [RW-1:0] got_tag[8];
   logic [31:0]   got_val[8];
   int            k, nres;
   logic [5:0]    ops[5] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd63};

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; RoB_clear = 1'b0;
      disp(0, 0, 0, 0, 0, 0, 0, 0, 0); bus.disp_valid = 1'b0;
      cdb(0, 0, 0);
      step(); step();
      chk_on = 1'b1;
      rst_in = 1'b0;
      check("reset rs_full", 32'(bus.rs_full), 32'd0);
      check("reset alu_waiting", 32'(bus.alu_waiting), 32'd0);
      check("reset res_valid", 32'(bus.res_valid), 32'd0);
      check("reset res_tag", 32'(bus.res_tag), 32'd0);

      // ready addi: 5 + 7 -> 12 on tag 3
      disp(6'd1, 32'd7, 0, 0, 32'd5, 0, 0, 0, 4'd3);
      step(); bus.disp_valid = 1'b0;
      step(); check("ready waiting E+1", 32'(bus.alu_waiting), 32'd1);
      step();
      check("ready res_valid E+2", 32'(bus.res_valid), 32'd1);
      check("ready res_tag", 32'(bus.res_tag), 32'd3);
      check("ready res_value", bus.res_value, 32'd12);
      step(); step();

      // dependent add woken by CDB tag 5 value 10: 10 + 2
      disp(6'd0, 0, 1, 4'd5, 0, 0, 0, 32'd2, 4'd1);
      step(); bus.disp_valid = 1'b0;
      step();
      cdb(1, 4'd5, 32'd10); step(); cdb(0, 0, 0);
      wait_res(4'd1, 6, seen, val);
      check("dep result seen", 32'(seen), 32'd1);
      check("dep res_value", val, 32'd12);
      step(); step();

      // fill all slots behind tag 9, then an ignored ready op
      for (int i = 0; i < 8; i++) begin
         disp(6'd1, 32'(i), 1, 4'd9, 0, 0, 0, 0, 4'(i)); step();
      end
      check("full after 8", 32'(bus.rs_full), 32'd1);
      disp(6'd1, 32'd1, 0, 0, 32'd1, 0, 0, 0, 4'd15); step();
      bus.disp_valid = 1'b0;
      check("full still", 32'(bus.rs_full), 32'd1);
      check("9th not issued", 32'(bus.alu_waiting), 32'd0);
      cdb(1, 4'd9, 32'd100); step(); cdb(0, 0, 0);
      k = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (c == 0) begin
            check("first issue", 32'(bus.alu_waiting), 32'd1);
            check("full at first issue", 32'(bus.rs_full), 32'd1);
         end
         if (c == 1) check("full falls", 32'(bus.rs_full), 32'd0);
         if (bus.res_valid && k < 8) begin got_tag[k] = bus.res_tag; got_val[k] = bus.res_value; k++; end
      end
      check("order count", 32'(k), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check("order tag", 32'(got_tag[i]), 32'(i));
         check("order value", got_val[i], 32'(100 + i));
      end

      // flush one cycle after an issue with 3 entries left
      for (int i = 0; i < 4; i++) begin
         disp(6'd0, 0, 1, 4'd9, 0, 0, 0, 32'd1, 4'(8 + i)); step();
      end
      bus.disp_valid = 1'b0;
      cdb(1, 4'd9, 32'd1); step(); cdb(0, 0, 0);
      step(); check("flush pre-issue", 32'(bus.alu_waiting), 32'd1);
      RoB_clear = 1'b1; step(); RoB_clear = 1'b0;
      check("flush rs_full", 32'(bus.rs_full), 32'd0);
      check("flush alu_waiting", 32'(bus.alu_waiting), 32'd0);
      check("flush res_tag", 32'(bus.res_tag), 32'd0);
      nres = 0;
      for (int c = 0; c < 5; c++) begin step(); if (bus.res_valid) nres++; end
      cdb(1, 4'd9, 32'd1); step(); cdb(0, 0, 0);
      for (int c = 0; c < 4; c++) begin step(); if (bus.res_valid) nres++; end
      check("flush no results", 32'(nres), 32'd0);

      // self bypass: A (tag 2) = 1+2, B = A + 3 on tag 4
      disp(6'd1, 32'd2, 0, 0, 32'd1, 0, 0, 0, 4'd2); step();
      disp(6'd0, 0, 1, 4'd2, 0, 0, 0, 32'd3, 4'd4); step();
      bus.disp_valid = 1'b0;
      wait_res(4'd4, 10, seen, val);
`ifdef ALU_RS_SELF_BYPASS_EN
      check("bypass B issued", 32'(seen), 32'd1);
      check("bypass B value", val, 32'd6);
`else
      check("no bypass B waits", 32'(seen), 32'd0);
      cdb(1, 4'd2, 32'd3); step(); cdb(0, 0, 0);
      wait_res(4'd4, 6, seen, val);
      check("B after cdb", 32'(seen), 32'd1);
      check("B value", val, 32'd6);
`endif
      step(); step();

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rdy_in = ($urandom % 8) != 0;
         RoB_clear = ($urandom % 250) == 0;
         disp(ops[$urandom % 5], $urandom, 1'($urandom), 4'($urandom), $urandom,
              1'($urandom), 4'($urandom), $urandom, 4'($urandom));
         bus.disp_valid = 1'($urandom);
         cdb(($urandom % 3) == 0, 4'($urandom), $urandom);
         step();
      end
      rdy_in = 1'b1; RoB_clear = 1'b0; bus.disp_valid = 1'b0; cdb(0, 0, 0);
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
